// File: rtl/seg_pkg.sv
// Shared constants and slot-state type for the seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_W = 4;
    localparam int VAL_W = NUM_DIGITS * BCD_W;
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

    typedef enum logic [1:0] {
        GUARD_OFF,
        ON,
        TAIL_OFF
    } slot_state_e;

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot timer: cycle counter, slot index, frame pulse and on-time window.
// Exports next-cycle slot/state so the top can register AN in step with cnt.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int REFRESH_CNT = 6250,
    parameter int GUARD = 64,
    parameter int CNT_W = 13
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  brightness_i,
    output logic [2:0]  slot_o,
    output logic        frame_start_o,
    output logic [2:0]  slot_nxt_o,
    output slot_state_e state_nxt_o
);

    localparam int LW = CNT_W + 3;
    localparam logic [LW-1:0] ACTIVE_L = LW'(REFRESH_CNT - GUARD);
    localparam logic [LW-1:0] GUARD_L = LW'(GUARD);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_CNT - 1);

    if (GUARD >= REFRESH_CNT || ((REFRESH_CNT - GUARD) >> 3) < 1 ||
        REFRESH_CNT > (1 << CNT_W)) begin : g_param_err
        $error("seg_slot_timer: invalid REFRESH_CNT/GUARD/CNT_W combination");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       slot_q, slot_d;
    logic [LW-1:0]    on_len_q, on_len_d;
    logic             fs_q, fs_d;
    logic             wrap;
    logic [LW-1:0]    cnt_ext;
    slot_state_e      state_d;

    always_comb begin
        wrap = (cnt_q == LAST_CNT);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        slot_d = wrap ? slot_q + 3'd1 : slot_q;
        fs_d = wrap && (slot_q == 3'd7);
        // brightness is captured once, in the cnt==0 cycle of every slot
        on_len_d = on_len_q;
        if (cnt_q == '0) begin
            on_len_d = ((LW'(brightness_i) + LW'(1)) * ACTIVE_L) >> 3;
        end
        cnt_ext = LW'(cnt_d);
        if (cnt_ext < GUARD_L) begin
            state_d = GUARD_OFF;
        end else if (cnt_ext < GUARD_L + on_len_d) begin
            state_d = ON;
        end else begin
            state_d = TAIL_OFF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            slot_q <= '0;
            on_len_q <= '0;
            fs_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            slot_q <= slot_d;
            on_len_q <= on_len_d;
            fs_q <= fs_d;
        end
    end

    assign slot_o = slot_q;
    assign frame_start_o = fs_q;
    assign slot_nxt_o = rst_i ? 3'd0 : slot_d;
    assign state_nxt_o = rst_i ? GUARD_OFF : state_d;

endmodule

// File: rtl/seg_scan_controller.sv
// Eight-digit seven-segment scan controller with frame-aligned value update.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int REFRESH_CNT = 6250,
    parameter int GUARD = 64,
    parameter int CNT_W = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VAL_W-1:0]      value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [2:0]            brightness,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [BCD_W-1:0]      digit_out,
    output logic [2:0]            slot,
    output logic                  frame_start
);

    logic [2:0]  slot_nxt;
    slot_state_e state_nxt;

    seg_slot_timer #(
        .REFRESH_CNT(REFRESH_CNT),
        .GUARD(GUARD),
        .CNT_W(CNT_W)
    ) u_timer (
        .clk_i(clk),
        .rst_i(reset),
        .brightness_i(brightness),
        .slot_o(slot),
        .frame_start_o(frame_start),
        .slot_nxt_o(slot_nxt),
        .state_nxt_o(state_nxt)
    );

    logic [VAL_W-1:0]      shadow_q, shadow_d, disp_q, disp_d;
    logic                  full_q, full_d;
    logic [NUM_DIGITS-1:0] an_q, an_d, blank_d;
    logic [BCD_W-1:0]      dig_q, dig_d;
    logic                  accept, copy;

    assign accept = value_valid && !full_q;
    assign copy = frame_start && full_q;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [VAL_W-1:0] v);
        logic zero_above;
        lzb_mask = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (v[BCD_W*i +: BCD_W] == '0);
            lzb_mask[i] = zero_above;
        end
    endfunction

    logic [NUM_DIGITS-1:0] blank_q;

    assign blank_d = copy ? lzb_mask(shadow_q) : blank_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blank_q <= lzb_mask('0);
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    assign blank_d = '0;
`endif

    always_comb begin
        shadow_d = shadow_q;
        full_d = full_q;
        disp_d = disp_q;
        if (accept) begin
            shadow_d = value_in;
            full_d = 1'b1;
        end
        if (copy) begin
            disp_d = shadow_q;
            full_d = 1'b0;
        end
        // AN and digit_out are built from next-cycle slot/state so they stay aligned with cnt
        an_d = AN_ALL_OFF;
        if (state_nxt == ON && digit_en[slot_nxt] && !blank_d[slot_nxt]) begin
            an_d[slot_nxt] = 1'b0;
        end
        dig_d = disp_d[BCD_W*slot_nxt +: BCD_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            full_q <= 1'b0;
            disp_q <= '0;
            an_q <= AN_ALL_OFF;
            dig_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            full_q <= full_d;
            disp_q <= disp_d;
            an_q <= an_d;
            dig_q <= dig_d;
        end
    end

    assign AN = an_q;
    assign digit_out = dig_q;
    assign value_ready = !full_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with REFRESH_CNT=16, GUARD=2.
module tb_seg_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic [7:0]  digit_en;
    logic [2:0]  brightness;
    logic [7:0]  AN;
    logic [3:0]  digit_out;
    logic [2:0]  slot;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .REFRESH_CNT(16),
        .GUARD(2),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value_in(value_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .digit_en(digit_en),
        .brightness(brightness),
        .AN(AN),
        .digit_out(digit_out),
        .slot(slot),
        .frame_start(frame_start)
    );

    typedef struct {
        logic [2:0] bright;
        logic [7:0] den;
        int         on_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (frame_start === 1'b1) begin
                n = i;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_frame: no frame_start within 200 cycles");
    endtask

    function automatic logic [7:0] exp_vis(input logic [7:0] den, input logic [31:0] shown);
        logic [7:0] m;
        m = den;
`ifdef LEADING_ZERO_BLANK_EN
        for (int d = 7; d >= 1; d--) begin
            if (shown[31:4*d] != 0) break;
            m[d] = 1'b0;
        end
`endif
        return m;
    endfunction

    // Starts at a frame_start sample; ends at the last cycle of that frame.
    task automatic check_an_frame(input int on_cyc, input logic [7:0] den, input logic [31:0] shown);
        logic [7:0] vis, e;
        int c, s;
        vis = exp_vis(den, shown);
        for (int k = 0; k < 128; k++) begin
            if (k > 0) step();
            c = k % 16;
            s = k / 16;
            e = 8'hFF;
            if (c >= 2 && c < 2 + on_cyc && vis[s]) e = ~(8'h01 << s);
            chk($sformatf("AN k=%0d on=%0d en=%0h", k, on_cyc, den), AN, e);
            if (c == 0) begin
                chk($sformatf("slot k=%0d", k), slot, s);
                chk($sformatf("frame_start k=%0d", k), frame_start, k == 0);
            end
        end
    endtask

    // Current sample is frame position k0; checks digit_out mid-slot up to k=127.
    task automatic check_digits(input logic [31:0] val, input int k0);
        logic [3:0] nib;
        for (int k = k0 + 1; k < 128; k++) begin
            step();
            if (k % 16 == 5) begin
                nib = val[4*(k/16) +: 4];
                chk($sformatf("digit_out val=%0h slot=%0d", val, k / 16), digit_out, nib);
            end
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{bright: 3'd7, den: 8'hFF, on_cyc: 14};
        vecs[1] = '{bright: 3'd0, den: 8'hFF, on_cyc: 1};
        vecs[2] = '{bright: 3'd3, den: 8'hFF, on_cyc: 7};
        vecs[3] = '{bright: 3'd7, den: 8'h0F, on_cyc: 14};
        vecs[4] = '{bright: 3'd5, den: 8'hA5, on_cyc: 10};

        reset = 1'b1;
        value_in = '0;
        value_valid = 1'b0;
        digit_en = 8'hFF;
        brightness = 3'd7;
        repeat (3) step();
        chk("rst AN", AN, 8'hFF);
        chk("rst digit_out", digit_out, 4'd0);
        chk("rst slot", slot, 3'd0);
        chk("rst frame_start", frame_start, 1'b0);
        chk("rst value_ready", value_ready, 1'b1);
        reset = 1'b0;
        wait_frame(n);
        chk("first frame_start distance", n, 128);
        wait_frame(n);
        chk("frame_start period", n, 128);

        for (int v = 0; v < 5; v++) begin
            brightness = vecs[v].bright;
            digit_en = vecs[v].den;
            wait_frame(n);
            check_an_frame(vecs[v].on_cyc, vecs[v].den, 32'h0);
        end
        brightness = 3'd7;
        digit_en = 8'hFF;

        // single update mid-frame
        wait_frame(n);
        repeat (40) step();
        value_in = 32'h12345678;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        chk("ready drops after accept", value_ready, 1'b0);
        chk("old digit before boundary", digit_out, 4'd0);
        wait_frame(n);
        chk("ready low at frame_start", value_ready, 1'b0);
        step();
        chk("ready back after frame_start", value_ready, 1'b1);
        chk("slot0 new digit", digit_out, 4'h8);
        check_digits(32'h12345678, 1);

        // A accepted, B held across the boundary
        wait_frame(n);
        repeat (20) step();
        value_in = 32'h87654321;
        value_valid = 1'b1;
        step();
        chk("A accepted", value_ready, 1'b0);
        value_in = 32'h24681357;
        wait_frame(n);
        chk("B not taken at copy", value_ready, 1'b0);
        step();
        chk("ready rises with B waiting", value_ready, 1'b1);
        step();
        value_valid = 1'b0;
        chk("B accepted", value_ready, 1'b0);
        check_digits(32'h87654321, 2);
        wait_frame(n);
        step();
        chk("ready after B copy", value_ready, 1'b1);
        check_digits(32'h24681357, 1);

        // pending value discarded by reset at slot 5
        wait_frame(n);
        step();
        value_in = 32'h99999999;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        chk("C accepted", value_ready, 1'b0);
        repeat (82) step();
        chk("slot before reset", slot, 3'd5);
        reset = 1'b1;
        step();
        chk("mid rst AN", AN, 8'hFF);
        chk("mid rst slot", slot, 3'd0);
        chk("mid rst ready", value_ready, 1'b1);
        chk("mid rst digit_out", digit_out, 4'd0);
        chk("mid rst frame_start", frame_start, 1'b0);
        reset = 1'b0;
        wait_frame(n);
        chk("frame_start after mid reset", n, 128);
        check_digits(32'h0, 0);

`ifdef LEADING_ZERO_BLANK_EN
        value_in = 32'h00000405;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        wait_frame(n);
        check_an_frame(14, 8'hFF, 32'h00000405);
        value_in = 32'h0;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        wait_frame(n);
        check_an_frame(14, 8'hFF, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the board's eight-digit seven-segment display. It owns the anode scan, the per-digit refresh timing, brightness (on-time duty), anti-ghosting guard time and tear-free update of the displayed 32-bit BCD value. It sits between the BCD counter datapath, which offers `value_in` through a valid/ready handshake, and the `x7Seg` decoder, which consumes `digit_out`.

## Interface
- `REFRESH_CNT`, default 6250: clock cycles per digit slot.
- `GUARD`, default 64: cycles at the start of each slot with all anodes off (anti-ghosting); must be less than `REFRESH_CNT`.
- `CNT_W`, default 13: width of the slot cycle counter; must hold `REFRESH_CNT-1`.
- `clk` in 1: system clock (single clock domain).
- `reset` in 1: synchronous, active-high reset.
- `value_in` in 32: eight packed BCD digits; digit 0 is `[3:0]`.
- `value_valid` in 1: `value_in` is offered.
- `value_ready` out 1: shadow register is empty and can accept.
- `digit_en` in 8: per-digit enable; 0 keeps that anode off.
- `brightness` in 3: on-time level, 0 = dimmest, 7 = full.
- `AN` out 8: anodes, active-low.
- `digit_out` out 4: BCD nibble for the current slot, to `x7Seg`.
- `slot` out 3: current digit index.
- `frame_start` out 1: one-cycle pulse at the start of slot 0.

## Operation
- Reset values:
  - `AN`=8'hFF, `digit_out`=0, `slot`=0, `frame_start`=0, `value_ready`=1.
  - Displayed register = 0, shadow empty, slot counter `cnt`=0.
- Slot counter:
  - `cnt` increments every cycle.
  - At `cnt==REFRESH_CNT-1`, `cnt` goes to 0 and `slot` goes to `slot+1`, wrapping from 7 to 0.
  - A frame is `8*REFRESH_CNT` cycles.
- Per-slot FSM, states GUARD_OFF → ON → TAIL_OFF → GUARD_OFF:
  - GUARD_OFF while `cnt<GUARD`.
  - ON while `GUARD<=cnt<GUARD+on_len`.
  - TAIL_OFF for the rest of the slot.
  - `on_len = ((brightness+1)*(REFRESH_CNT-GUARD))>>3`, computed in `CNT_W+3` bits.
  - `brightness` is sampled once per slot at `cnt==0`.
- `AN`:
  - `AN[slot]`=0 only in ON, and only if `digit_en[slot]` is set and the digit is not blanked.
  - All other bits are 1.
  - At most one bit of `AN` is ever 0.
- `digit_out` = displayed register `[4*slot +: 4]`, updated in the same cycle `slot` changes.
- Handshake:
  - Transfer occurs when `value_valid && value_ready`. The value is written to the shadow register and `value_ready` drops the next cycle.
  - When `frame_start` fires with the shadow full, shadow copies to the displayed register and `value_ready` returns to 1 on the following cycle.
  - A `value_valid` in the same cycle as that copy is not accepted (`value_ready` is still 0).
  - The displayed value therefore changes only on frame boundaries; no frame ever shows mixed digits.
- Holding `value_valid` high with `value_ready` low: the producer must hold `value_in` stable (standard valid/ready).
- Reset mid-frame: everything returns to its reset value on the next edge. A pending shadow value is discarded and the next frame shows 0.

## Timing
- `cnt`, `slot`, `AN`, `digit_out` and `frame_start` are all registered; all outputs are glitch-free.
- `frame_start` is high in the cycle where `slot==0 && cnt==0`, and not in the cycle immediately after reset.
- Latency from accepted `value_in` to visible value: up to one frame plus 1 cycle.
- The first ON cycle of a slot is `cnt==GUARD`.
- With `brightness==7`, ON lasts `REFRESH_CNT-GUARD` cycles; with `brightness==0`, it lasts `(REFRESH_CNT-GUARD)>>3` cycles, and that must be ≥1 (parameter check).

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - A digit is blanked when it and every higher-index digit of the displayed register are 0.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - The blank mask is computed once per frame, at the copy.
- Not defined: no blanking; only `digit_en` gates anodes.

## Structure
- Shared package `seg_pkg` holds:
  - `NUM_DIGITS`=8, `AN_ALL_OFF`=8'hFF, `BCD_W`=4.
  - The slot-state enum (GUARD_OFF, ON, TAIL_OFF).
- One natural sub-module, `seg_slot_timer`: owns `cnt`, `slot`, the `frame_start` pulse and the `on_len` compare, and exports the state.
- The top keeps the handshake, shadow/displayed registers, blanking and the `AN`/`digit_out` registers.

## Test plan
All scenarios use `REFRESH_CNT`=16, `GUARD`=2.
- Reset then idle, `digit_en`=8'hFF, `brightness`=7, value 0 → `AN` walks 8'hFE…8'h7F.
  - Each slot: `AN`=8'hFF for cycles 0–1, then low for 14 cycles.
  - `frame_start` every 128 cycles.
- `brightness`=0 → `AN[slot]` is low exactly 1 cycle per slot (cnt=2). `brightness`=3 → low 7 cycles (cnt 2–8).
- Offer 32'h12345678 mid-frame → `value_ready` drops the next cycle. `digit_out` still shows old digits until `frame_start`, then slot 0 shows 8 and slot 7 shows 1. `value_ready` returns high 1 cycle after `frame_start`.
- Offer A, then hold B valid while `value_ready`=0 across the boundary → A displayed first. B is accepted the cycle after `value_ready` rises and is displayed one frame later.
- `LEADING_ZERO_BLANK_EN` with value 32'h00000405 → anodes 3–7 stay off and anodes 0–2 are active. Value 0 → only anode 0 is active.
- `digit_en`=8'h0F → `AN[7:4]` never low. Assert `reset` at slot 5 → `AN`=8'hFF and `slot`=0 next cycle, shadow cleared, `value_ready`=1.
